// File: rtl/module_bin_bcd.sv
// module_bin_bcd: sequential binary-to-BCD converter (shift-and-add-3).
// A start pulse captures one binary sample. ANCHO_BIN clock edges later the
// four BCD digits are presented and listo is raised.
// Optional feature macro: BCD_SATURA_EN adds the desborde output and saturates
// the digits to 9999 when the captured value exceeds 9999.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// REPOSO   | idle; digits and listo are held, waiting for inicio
// DESPLAZA | conversion running; one adjust+shift step per edge
module module_bin_bcd #(
  parameter int ANCHO_BIN = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ANCHO_BIN-1:0] binario,
  input  logic                 inicio,
  output logic [3:0]           unidades,
  output logic [3:0]           decenas,
  output logic [3:0]           centenas,
  output logic [3:0]           millares,
  output logic                 listo,
  output logic                 ocupado
`ifdef BCD_SATURA_EN
  , output logic               desborde
`endif
);

  localparam int CNT_W = $clog2(ANCHO_BIN);

  typedef enum logic {REPOSO = 1'b0, DESPLAZA = 1'b1} estado_t;

  estado_t              estado, estado_sig;
  logic [ANCHO_BIN-1:0] shreg, sh_nxt;
  logic [15:0]          acc, acc_adj, acc_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 carga, desplaza, fin;

`ifdef BCD_SATURA_EN
  logic        sat;
  logic [31:0] bin_ext;
  assign bin_ext = {{(32-ANCHO_BIN){1'b0}}, binario};
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  // Next-state logic
  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:   if (inicio)      estado_sig = DESPLAZA;
      DESPLAZA: if (cnt == '0)   estado_sig = REPOSO;
      default:                   estado_sig = REPOSO;
    endcase
  end

  // Datapath control decoded from the current state
  always_comb begin
    carga    = 1'b0;
    desplaza = 1'b0;
    fin      = 1'b0;
    case (estado)
      REPOSO:   carga = inicio;
      DESPLAZA: begin
        desplaza = 1'b1;
        fin      = (cnt == '0);
      end
      default: ;
    endcase
  end

  // Add 3 to every nibble >= 5, then shift {acc, shreg} left; the bit leaving
  // the thousands nibble is the discarded ten-thousands carry
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    {acc_nxt, sh_nxt} = {acc_adj, shreg} << 1;
  end

  // Conversion registers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      unidades <= '0;
      decenas  <= '0;
      centenas <= '0;
      millares <= '0;
      listo    <= 1'b0;
      ocupado  <= 1'b0;
`ifdef BCD_SATURA_EN
      sat      <= 1'b0;
      desborde <= 1'b0;
`endif
    end else if (carga) begin
      shreg   <= binario;
      acc     <= '0;
      cnt     <= CNT_W'(ANCHO_BIN - 1);
      listo   <= 1'b0;
      ocupado <= 1'b1;
`ifdef BCD_SATURA_EN
      sat     <= (bin_ext > 32'd9999);
`endif
    end else if (desplaza) begin
      shreg <= sh_nxt;
      acc   <= acc_nxt;
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      if (fin) begin
        listo   <= 1'b1;
        ocupado <= 1'b0;
`ifdef BCD_SATURA_EN
        desborde <= sat;
        if (sat) begin
          {millares, centenas, decenas, unidades} <= 16'h9999;
        end else begin
          {millares, centenas, decenas, unidades} <= acc_nxt;
        end
`else
        {millares, centenas, decenas, unidades} <= acc_nxt;
`endif
      end
    end
  end

endmodule
